dffram_ahbl_ctrl: RTL and testbench
===================================

Name: dffram_ahbl_ctrl

Overview:
Parametrised AHB-Lite slave controller for single-port DFFRAM macros of any depth. It exposes a generic SRAM port so one controller serves RAM256/512/1024/2048 macros, with or without a registered output stage. Writes are posted: a write buffer defers each write past any following read, and forwards pending bytes when a read hits the buffered word. Other behaviour:
- Configurable read latency (zero or one wait state).
- Two-cycle ERROR response for misaligned or oversized transfers.

Parameters:
NUM_WORDS, 256, RAM depth in 32-bit words; power of two, 32..2048
AW, $clog2(NUM_WORDS), word-address width (derived, not overridden)
RAM_RLAT, 0, macro read latency: 0 = data one cycle after EN; 1 = two cycles after EN (registered Do)
ERR_EN, 1, 1 = misaligned or HSIZE>2 transfers get ERROR; 0 = accept them, with lanes decoded as word

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slave select
HADDR  in  32  byte address; bits [AW+1:2] used, upper bits ignored (aliasing)
HTRANS  in  2  transfer type; only HTRANS[1] is decoded
HWRITE  in  1  write/read
HSIZE  in  3  transfer size
HREADY  in  1  bus ready
HWDATA  in  32  write data
HREADYOUT  out  1  slave ready
HRESP  out  1  0 = OKAY, 1 = ERROR
HRDATA  out  32  read data
ram_en  out  1  macro enable
ram_we  out  4  byte write enables
ram_addr  out  AW  word address
ram_wdata  out  32  macro write data
ram_rdata  in  32  macro read data

Behaviour:
- Interface: reset HRESETn, asynchronous, active-low; clock HCLK.
- Reset values: HREADYOUT=1, HRESP=0, ram_we=0, ram_en=0, buffer invalid, FSM in IDLE. HRDATA is don't-care outside read data phases.
- Request decode: acc = HSEL & HREADY & HTRANS[1]; wr = acc & HWRITE; rd = acc & ~HWRITE.
- Illegal transfer (ERR_EN=1): HSIZE>2, or halfword with HADDR[0]=1, or word with HADDR[1:0]!=0.
  - Illegal transfers never touch the RAM or the buffer.
- FSM states: IDLE, RWAIT, ERR1, ERR2.
  - IDLE -> ERR1 on an illegal acc.
  - IDLE -> RWAIT on a legal rd when RAM_RLAT=1.
  - Otherwise IDLE -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=1; -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1; -> IDLE. A new acc is sampled in this cycle per IDLE rules.
  - RWAIT: HREADYOUT=0, HRESP=0; -> IDLE. HRDATA is valid in the following cycle.
- Read latency: RAM_RLAT=0 gives zero wait states; RAM_RLAT=1 gives one wait state. Writes are always zero wait.
- Byte lanes: decoded from HSIZE/HADDR[1:0] in the address phase and captured with the address into buf_we/buf_addr on wr.
- Write buffer data: in the write data phase, buf_data is updated with HWDATA, enabled lanes only, and the buffer becomes pending.
- Write buffer drain: a pending write is issued to the RAM in the first cycle with no legal rd in the address phase. This includes the write's own data phase and RWAIT cycles.
  - Drain cycle outputs: ram_en=1, ram_we=buf_we, ram_addr=buf_addr, ram_wdata = HWDATA in the data phase, otherwise buf_data.
  - Pending clears after the drain.
- Read issue: ram_en=1, ram_we=0, ram_addr=HADDR[AW+1:2]. A read always has priority over a drain.
- Forwarding:
  - hit = (HADDR[AW+1:2]==buf_addr) & (pending | write data phase), sampled at read address phase.
  - In the read data phase, lanes with hit & buf_we[i] return buf_data; other lanes return ram_rdata.
- Back-to-back writes: the second write's address phase coincides with the first write's data phase, so the first drains in that same cycle and the buffer never holds two writes.
- Write then reads: W, R, R… keeps the write pending until the first non-read cycle. Forwarding stays correct throughout.
- Reset mid-operation: pending write data is lost. The RAM contents are not cleared.

Decomposition:
- Package dffram_ahbl_pkg holds:
  - HTRANS/HSIZE/HRESP encodings;
  - FSM state enum;
  - a lane-decode function (HSIZE, HADDR[1:0]) -> {legal, we[3:0]}.
- One sub-module, dffram_wbuf, contains the write buffer (data, address, lane enables, pending, hit and forward mux). The FSM and decode live in the top module.

Test Plan:
- Word write 0xDEADBEEF @0x10, then an idle cycle, then read @0x10 -> ram_we=4'hF in the write data phase; HRDATA=0xDEADBEEF with zero waits (RAM_RLAT=0).
- Write 0x11223344 @0x20 then immediate read @0x20 -> no drain during the read; HRDATA=0x11223344 via forwarding; drain happens on the next idle cycle.
- Byte write 0xAA @0x23 over 0x11223344, then read @0x20 -> ram_we=4'b1000; HRDATA=0xAA223344.
- Halfword @0x01 -> HREADYOUT 0 then 1, HRESP 1,1; RAM unchanged; the next read @0x00 is OKAY.
- RAM_RLAT=1: read @0x40 -> exactly one HREADYOUT=0 cycle, then correct data; a pending write to 0x44 drains during RWAIT.
- NUM_WORDS=512: write @0x800 -> aliases to word 0; reset asserted mid-write data phase -> no RAM write and all outputs at reset values.

Source files
------------

// File: rtl/dffram_ahbl_pkg.sv
// Shared AHB-Lite encodings, controller FSM states and
// byte-lane decode for the DFFRAM AHB-Lite controller.
package dffram_ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RWAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] we;
    } lane_t;

    // Anything not naturally aligned falls back to full-word lanes.
    function automatic lane_t lane_decode(
        input logic [2:0] size,
        input logic [1:0] a
    );
        lane_t r;
        r.legal = 1'b0;
        r.we    = 4'hF;
        unique case (size)
            HSIZE_BYTE: begin
                r.legal = 1'b1;
                r.we    = 4'b0001 << a;
            end
            HSIZE_HALF: begin
                r.legal = ~a[0];
                if (!a[0])
                    r.we = a[1] ? 4'b1100 : 4'b0011;
            end
            HSIZE_WORD: begin
                r.legal = (a == 2'b00);
            end
            default: begin
                r.legal = 1'b0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dffram_wbuf.sv
// Single-entry posted-write buffer with read-hit byte forwarding
// for the DFFRAM AHB-Lite controller.
module dffram_wbuf
    import dffram_ahbl_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cap,
    input  logic [AW-1:0] i_cap_addr,
    input  logic [3:0]    i_cap_we,
    input  logic          i_wdp,
    input  logic [31:0]   i_wdata,
    input  logic          i_drain,
    input  logic          i_rd,
    input  logic [AW-1:0] i_rd_addr,
    input  logic [31:0]   i_ram_rdata,
    output logic          o_pend,
    output logic [AW-1:0] o_addr,
    output logic [3:0]    o_we,
    output logic [31:0]   o_data,
    output logic [31:0]   o_rdata
);

    logic [31:0]   r_data;
    logic [AW-1:0] r_addr;
    logic [3:0]    r_we;
    logic          r_pend;
    logic [3:0]    r_fwd;
    logic          w_hit;

    // A write still in its data phase counts as buffered.
    assign w_hit = (i_rd_addr == r_addr) & (r_pend | i_wdp);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
            r_addr <= '0;
            r_we   <= '0;
            r_pend <= 1'b0;
            r_fwd  <= '0;
        end else begin
            if (i_cap) begin
                r_addr <= i_cap_addr;
                r_we   <= i_cap_we;
            end
            if (i_wdp) begin
                for (int i = 0; i < 4; i++)
                    if (r_we[i])
                        r_data[8*i +: 8] <= i_wdata[8*i +: 8];
            end
            if (i_drain)
                r_pend <= 1'b0;
            else if (i_wdp)
                r_pend <= 1'b1;
            if (i_rd)
                r_fwd <= w_hit ? r_we : 4'h0;
        end
    end

    always_comb begin
        o_rdata = i_ram_rdata;
        for (int i = 0; i < 4; i++)
            if (r_fwd[i])
                o_rdata[8*i +: 8] = r_data[8*i +: 8];
    end

    assign o_pend = r_pend;
    assign o_addr = r_addr;
    assign o_we   = r_we;
    assign o_data = r_data;

endmodule

// File: rtl/dffram_ahbl_ctrl.sv
// AHB-Lite slave controller for single-port DFFRAM macros with
// posted writes, optional read wait state and ERROR responses.
module dffram_ahbl_ctrl
    import dffram_ahbl_pkg::*;
#(
    parameter int NUM_WORDS = 256,
    parameter int AW        = $clog2(NUM_WORDS),
    parameter int RAM_RLAT  = 0,
    parameter bit ERR_EN    = 1'b1
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic          HREADY,
    input  logic [31:0]   HWDATA,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    output logic          ram_en,
    output logic [3:0]    ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    state_t        r_state;
    state_t        w_next;
    logic          r_wdp;
    lane_t         w_lane;
    logic          w_acc;
    logic          w_legal;
    logic          w_bad;
    logic          w_wr;
    logic          w_rd;
    logic          w_drain;
    logic [AW-1:0] w_addr;
    logic          w_pend;
    logic [AW-1:0] w_buf_addr;
    logic [3:0]    w_buf_we;
    logic [31:0]   w_buf_data;
    logic          w_hreadyout;
    logic          w_hresp;
    logic          w_unused;

    assign w_unused = &{1'b0, HTRANS[0], HADDR[31:AW+2]};

    assign w_acc   = HSEL & HREADY & HTRANS[1];
    assign w_lane  = lane_decode(HSIZE, HADDR[1:0]);
    assign w_legal = w_lane.legal | ~ERR_EN;
    assign w_bad   = w_acc & ~w_legal;
    assign w_wr    = w_acc & HWRITE & w_legal;
    assign w_rd    = w_acc & ~HWRITE & w_legal;
    assign w_addr  = HADDR[AW+1:2];

    // Reads always win the port; the buffered write waits.
    assign w_drain = (w_pend | r_wdp) & ~w_rd;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
            r_wdp   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wdp   <= w_wr;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_hreadyout = 1'b1;
        w_hresp     = HRESP_OKAY;
        unique case (r_state)
            ST_IDLE, ST_ERR2: begin
                if (r_state == ST_ERR2)
                    w_hresp = HRESP_ERROR;
                if (w_bad)
                    w_next = ST_ERR1;
                else if (w_rd && RAM_RLAT != 0)
                    w_next = ST_RWAIT;
                else
                    w_next = ST_IDLE;
            end
            ST_RWAIT: begin
                w_hreadyout = 1'b0;
                w_next      = ST_IDLE;
            end
            ST_ERR1: begin
                w_hreadyout = 1'b0;
                w_hresp     = HRESP_ERROR;
                w_next      = ST_ERR2;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    dffram_wbuf #(
        .AW(AW)
    ) u_wbuf (
        .i_clk       (HCLK),
        .i_rst_n     (HRESETn),
        .i_cap       (w_wr),
        .i_cap_addr  (w_addr),
        .i_cap_we    (w_lane.we),
        .i_wdp       (r_wdp),
        .i_wdata     (HWDATA),
        .i_drain     (w_drain),
        .i_rd        (w_rd),
        .i_rd_addr   (w_addr),
        .i_ram_rdata (ram_rdata),
        .o_pend      (w_pend),
        .o_addr      (w_buf_addr),
        .o_we        (w_buf_we),
        .o_data      (w_buf_data),
        .o_rdata     (HRDATA)
    );

    assign ram_en    = w_rd | w_drain;
    assign ram_we    = w_drain ? w_buf_we : 4'h0;
    assign ram_addr  = w_rd ? w_addr : w_buf_addr;
    assign ram_wdata = r_wdp ? HWDATA : w_buf_data;

    assign HREADYOUT = w_hreadyout;
    assign HRESP     = w_hresp;

endmodule

// File: tb/tb_dffram_ahbl_ctrl.sv
// Scoreboard bench for dffram_ahbl_ctrl: one 256-word zero-wait
// instance and one 512-word instance with a registered macro output.
module tb_dffram_ahbl_ctrl;
    import dffram_ahbl_pkg::*;

    logic        HCLK;
    logic        HRESETn;
    logic [1:0]  sel;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;

    logic [1:0]        hro;
    logic [1:0]        hrsp;
    logic [1:0][31:0]  hrd;
    logic [1:0]        en;
    logic [1:0][3:0]   we;
    logic [1:0][10:0]  ra;
    logic [1:0][31:0]  wdat;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    for (genvar g = 0; g < 2; g++) begin : g_i
        localparam int NW  = (g == 0) ? 256 : 512;
        localparam int RL  = (g == 0) ? 0 : 1;
        localparam int AWL = $clog2(NW);
        logic [AWL-1:0] addr;
        logic [31:0]    mem [NW];
        logic [31:0]    do1;
        logic [31:0]    do2;
        logic [31:0]    rdata;

        dffram_ahbl_ctrl #(
            .NUM_WORDS(NW),
            .RAM_RLAT (RL),
            .ERR_EN   (1'b1)
        ) u_dut (
            .HCLK      (HCLK),
            .HRESETn   (HRESETn),
            .HSEL      (sel[g]),
            .HADDR     (HADDR),
            .HTRANS    (HTRANS),
            .HWRITE    (HWRITE),
            .HSIZE     (HSIZE),
            .HREADY    (hro[g]),
            .HWDATA    (HWDATA),
            .HREADYOUT (hro[g]),
            .HRESP     (hrsp[g]),
            .HRDATA    (hrd[g]),
            .ram_en    (en[g]),
            .ram_we    (we[g]),
            .ram_addr  (addr),
            .ram_wdata (wdat[g]),
            .ram_rdata (rdata)
        );

        assign ra[g] = 11'(addr);
        assign rdata = (RL != 0) ? do2 : do1;

        initial begin
            do1 = '0;
            do2 = '0;
            for (int i = 0; i < NW; i++)
                mem[i] = '0;
        end

        always @(posedge HCLK) begin
            if (en[g]) begin
                for (int i = 0; i < 4; i++)
                    if (we[g][i])
                        mem[addr][8*i +: 8] <= wdat[g][8*i +: 8];
                do1 <= mem[addr];
            end
            do2 <= do1;
        end
    end

    typedef struct {
        logic        rd;
        logic        resp;
        logic [31:0] data;
        int          waits;
    } exp_t;

    exp_t        sb[$];
    string       tq[$];
    int          n_chk;
    int          n_fail;
    logic [31:0] nwd;
    logic        o_en;
    logic [3:0]  o_we;
    logic [10:0] o_ra;
    logic [31:0] o_wd;
    logic        w_en;
    logic [3:0]  w_we;
    logic [10:0] w_ra;
    logic [31:0] w_wd;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive an address phase, retire the data phase.
    task automatic beat(input int d, input string tag, input logic t,
                        input logic w, input logic [2:0] s,
                        input logic [31:0] a, input logic [31:0] data,
                        input logic resp, input int waits);
        int    nw;
        exp_t  e;
        string tg;
        nw     = 0;
        sel    = (d == 0) ? 2'b01 : 2'b10;
        HTRANS = t ? HTRANS_NONSEQ : HTRANS_IDLE;
        HWRITE = w;
        HSIZE  = s;
        HADDR  = a;
        HWDATA = nwd;
        w_en   = 1'b1;
        w_we   = 4'h0;
        w_ra   = '1;
        w_wd   = '0;
        @(negedge HCLK);
        while (!hro[d] && nw < 8) begin
            if (nw == 0) begin
                w_en = en[d];
                w_we = we[d];
                w_ra = ra[d];
                w_wd = wdat[d];
            end
            nw++;
            if (sb.size() > 0)
                chk({tq[0], "_wresp"}, 32'(hrsp[d]), 32'(sb[0].resp));
            @(posedge HCLK);
            #1;
            @(negedge HCLK);
        end
        o_en = en[d];
        o_we = we[d];
        o_ra = ra[d];
        o_wd = wdat[d];
        if (!hro[d]) begin
            chk({tag, "_timeout"}, 32'(hro[d]), 32'd1);
            sb.delete();
            tq.delete();
        end else if (sb.size() > 0) begin
            e  = sb.pop_front();
            tg = tq.pop_front();
            chk({tg, "_resp"}, 32'(hrsp[d]), 32'(e.resp));
            chk({tg, "_waits"}, nw, e.waits);
            if (e.rd)
                chk({tg, "_rdata"}, hrd[d], e.data);
        end
        if (t && hro[d]) begin
            e.rd    = ~w & ~resp;
            e.resp  = resp;
            e.data  = data;
            e.waits = waits;
            sb.push_back(e);
            tq.push_back(tag);
            if (w)
                nwd = data;
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic wr(input int d, input string tag, input logic [2:0] s,
                      input logic [31:0] a, input logic [31:0] data);
        beat(d, tag, 1'b1, 1'b1, s, a, data, 1'b0, 0);
    endtask

    task automatic rd(input int d, input string tag, input logic [31:0] a,
                      input logic [31:0] exp, input int waits);
        beat(d, tag, 1'b1, 1'b0, HSIZE_WORD, a, exp, 1'b0, waits);
    endtask

    task automatic idle(input int d);
        beat(d, "idle", 1'b0, 1'b0, HSIZE_WORD, '0, '0, 1'b0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        nwd     = '0;
        HRESETn = 1'b0;
        sel     = 2'b00;
        HADDR   = '0;
        HTRANS  = HTRANS_IDLE;
        HWRITE  = 1'b0;
        HSIZE   = HSIZE_WORD;
        HWDATA  = '0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        for (int d = 0; d < 2; d++) begin
            chk("rst_hready", 32'(hro[d]), 32'd1);
            chk("rst_hresp", 32'(hrsp[d]), 32'd0);
            chk("rst_en", 32'(en[d]), 32'd0);
            chk("rst_we", 32'(we[d]), 32'd0);
        end
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;

        wr(0, "w10", HSIZE_WORD, 'h10, 'hDEADBEEF);
        idle(0);
        chk("w10_en", 32'(o_en), 32'd1);
        chk("w10_we", 32'(o_we), 32'hF);
        chk("w10_addr", 32'(o_ra), 32'h4);
        chk("w10_wd", o_wd, 32'hDEADBEEF);
        rd(0, "r10", 'h10, 'hDEADBEEF, 0);
        idle(0);

        wr(0, "w20", HSIZE_WORD, 'h20, 'h11223344);
        rd(0, "r20f", 'h20, 'h11223344, 0);
        chk("w20_hold_we", 32'(o_we), 32'h0);
        chk("r20_en", 32'(o_en), 32'd1);
        chk("r20_addr", 32'(o_ra), 32'h8);
        idle(0);
        chk("w20_drain_we", 32'(o_we), 32'hF);
        chk("w20_drain_addr", 32'(o_ra), 32'h8);
        chk("w20_drain_wd", o_wd, 32'h11223344);

        wr(0, "wb23", HSIZE_BYTE, 'h23, 'hAA000000);
        rd(0, "r20b", 'h20, 'hAA223344, 0);
        chk("wb23_hold_we", 32'(o_we), 32'h0);
        idle(0);
        chk("wb23_we", 32'(o_we), 32'h8);
        chk("wb23_wd", o_wd, 32'hAA223344);
        rd(0, "r20m", 'h20, 'hAA223344, 0);
        idle(0);

        wr(0, "w30", HSIZE_WORD, 'h30, 'h01020304);
        wr(0, "w34", HSIZE_WORD, 'h34, 'h05060708);
        chk("w30_b2b_we", 32'(o_we), 32'hF);
        chk("w30_b2b_addr", 32'(o_ra), 32'hC);
        chk("w30_b2b_wd", o_wd, 32'h01020304);
        idle(0);
        rd(0, "r30", 'h30, 'h01020304, 0);
        rd(0, "r34", 'h34, 'h05060708, 0);
        idle(0);

        beat(0, "half01", 1'b1, 1'b1, HSIZE_HALF, 'h01, 'h0000FFFF,
             1'b1, 1);
        idle(0);
        chk("err_en", 32'(w_en), 32'd0);
        rd(0, "r00", 'h00, 'h0, 0);
        idle(0);

        wr(1, "w40", HSIZE_WORD, 'h40, 'h12345678);
        idle(1);
        wr(1, "w44", HSIZE_WORD, 'h44, 'hCAFEF00D);
        rd(1, "r40", 'h40, 'h12345678, 1);
        chk("w44_hold_we", 32'(o_we), 32'h0);
        idle(1);
        chk("w44_rwait_we", 32'(w_we), 32'hF);
        chk("w44_rwait_addr", 32'(w_ra), 32'h11);
        chk("w44_rwait_wd", w_wd, 32'hCAFEF00D);
        rd(1, "r44", 'h44, 'hCAFEF00D, 1);
        idle(1);
        wr(1, "w48", HSIZE_WORD, 'h48, 'hA5A5A5A5);
        rd(1, "r48f", 'h48, 'hA5A5A5A5, 1);
        idle(1);

        wr(1, "w800", HSIZE_WORD, 'h800, 'h0BADF00D);
        idle(1);
        chk("w800_we", 32'(o_we), 32'hF);
        chk("w800_addr", 32'(o_ra), 32'h0);
        rd(1, "r000", 'h000, 'h0BADF00D, 1);
        idle(1);

        wr(1, "w04", HSIZE_WORD, 'h04, 'hFFFFFFFF);
        HTRANS  = HTRANS_IDLE;
        HWDATA  = 'hFFFFFFFF;
        HRESETn = 1'b0;
        #1;
        chk("mrst_en", 32'(en[1]), 32'd0);
        chk("mrst_we", 32'(we[1]), 32'h0);
        chk("mrst_hready", 32'(hro[1]), 32'd1);
        chk("mrst_hresp", 32'(hrsp[1]), 32'd0);
        @(posedge HCLK);
        @(negedge HCLK);
        chk("mrst_en2", 32'(en[1]), 32'd0);
        HRESETn = 1'b1;
        sb.delete();
        tq.delete();
        @(posedge HCLK);
        #1;
        rd(1, "r04", 'h04, 'h0, 1);
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
